// File: rtl/rf_wb_arbiter_pkg.sv
// rtl/rf_wb_arbiter_pkg.sv - shared types and helpers for the register-file write-back arbiter
package rf_wb_arbiter_pkg;

    localparam int DW_DEF = 16;
    localparam int AW_DEF = 4;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_LD  = 2'd1,
        SRC_MD  = 2'd2
    } src_t;

    typedef struct packed {
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] data;
    } wb_req_t;

    // Round-robin successor: ALU -> LOAD -> MD -> ALU
    function automatic src_t src_next(input src_t s);
        case (s)
            SRC_ALU: return SRC_LD;
            SRC_LD:  return SRC_MD;
            default: return SRC_ALU;
        endcase
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - small single-write request FIFO exposing per-entry addresses for hazard tracking
module wb_fifo #(
    parameter int DW    = 16,
    parameter int AW    = 4,
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [AW+DW-1:0]      push_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [AW+DW-1:0]      head,
    output logic [DEPTH-1:0]      ent_valid,
    output logic [DEPTH*AW-1:0]   ent_addr
);

    localparam int PW = $clog2(DEPTH);

    logic [AW+DW-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy tracking; a simultaneous push and pop leaves count unchanged
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop)
                count <= count + (PW+1)'(1);
            else if (do_pop && !do_push)
                count <= count - (PW+1)'(1);
        end
    end

    // Payload storage; validity is carried by count, so no reset is needed here
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        logic [PW-1:0] off;
        assign off                  = PW'(g) - rd_ptr;
        assign ent_valid[g]         = ({1'b0, off} < count);
        assign ent_addr[g*AW +: AW] = mem[g][AW+DW-1:DW];
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - packs ALU, LOAD and MULDIV results onto the two register-file write ports
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [AW-1:0]     alu_addr,
    input  logic [DW-1:0]     alu_data,
    output logic              alu_ready,
    input  logic              ld_valid,
    input  logic [AW-1:0]     ld_addr,
    input  logic [DW-1:0]     ld_data,
    output logic              ld_ready,
    input  logic              md_valid,
    input  logic [AW-1:0]     md_addr_a,
    input  logic [AW-1:0]     md_addr_b,
    input  logic [DW-1:0]     md_data_a,
    input  logic [DW-1:0]     md_data_b,
    output logic              md_ready,
    output logic              w_enable1,
    output logic              w_enable2,
    output logic [AW-1:0]     addr1,
    output logic [AW-1:0]     addr2,
    output logic [DW-1:0]     d1writeback,
    output logic [DW-1:0]     d2writeback,
    output logic [2**AW-1:0]  pending,
    output logic              idle
);

    localparam int EW = AW + DW;

    logic                alu_full, alu_empty, alu_pop;
    logic                ld_full, ld_empty, ld_pop;
    logic [EW-1:0]       alu_head, ld_head;
    logic [DEPTH-1:0]    alu_ev, ld_ev;
    logic [DEPTH*AW-1:0] alu_ea, ld_ea;

    logic                md_v;
    logic [AW-1:0]       md_aa, md_ab;
    logic [DW-1:0]       md_da, md_db;

    src_t                rr, rr_n, f_src, s_src;
    logic                ld_first, f_v, s_v, md_grant;
    logic [AW-1:0]       f_addr, s_addr;
    logic [DW-1:0]       f_data, s_data;

    logic                n_we1, n_we2;
    logic [AW-1:0]       n_a1, n_a2;
    logic [DW-1:0]       n_d1, n_d2;

    assign alu_ready = ~alu_full;
    assign ld_ready  = ~ld_full;
    assign md_ready  = ~md_v;

    wb_fifo #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_alu_fifo (
        .clk(clk), .rst(rst),
        .push(alu_valid & alu_ready), .push_data({alu_addr, alu_data}),
        .pop(alu_pop), .full(alu_full), .empty(alu_empty), .head(alu_head),
        .ent_valid(alu_ev), .ent_addr(alu_ea)
    );

    wb_fifo #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_ld_fifo (
        .clk(clk), .rst(rst),
        .push(ld_valid & ld_ready), .push_data({ld_addr, ld_data}),
        .pop(ld_pop), .full(ld_full), .empty(ld_empty), .head(ld_head),
        .ent_valid(ld_ev), .ent_addr(ld_ea)
    );

    // Order the two single sources for this cycle's scan: LOAD leads only when rr points at it
    assign ld_first = (rr == SRC_LD);
    assign f_src    = ld_first ? SRC_LD : SRC_ALU;
    assign s_src    = ld_first ? SRC_ALU : SRC_LD;
    assign f_v      = ld_first ? ~ld_empty : ~alu_empty;
    assign s_v      = ld_first ? ~alu_empty : ~ld_empty;
    assign f_addr   = ld_first ? ld_head[EW-1:DW] : alu_head[EW-1:DW];
    assign s_addr   = ld_first ? alu_head[EW-1:DW] : ld_head[EW-1:DW];
    assign f_data   = ld_first ? ld_head[DW-1:0] : alu_head[DW-1:0];
    assign s_data   = ld_first ? alu_head[DW-1:0] : ld_head[DW-1:0];
    assign md_grant = md_v & ((rr == SRC_MD) | (alu_empty & ld_empty));

    // Grant decision: MD pair takes both ports; otherwise pack up to two non-conflicting singles
    always_comb begin
        n_we1   = 1'b0;
        n_we2   = 1'b0;
        n_a1    = '0;
        n_a2    = '0;
        n_d1    = '0;
        n_d2    = '0;
        alu_pop = 1'b0;
        ld_pop  = 1'b0;
        rr_n    = rr;
        if (md_grant) begin
            n_we1 = 1'b1;
            n_a1  = md_aa;
            rr_n  = SRC_ALU;
            if (md_aa == md_ab) begin
                n_d1 = md_db;
            end else begin
                n_d1  = md_da;
                n_we2 = 1'b1;
                n_a2  = md_ab;
                n_d2  = md_db;
            end
        end else if (f_v) begin
            n_we1 = 1'b1;
            n_a1  = f_addr;
            n_d1  = f_data;
            if (s_v && (s_addr != f_addr)) begin
                n_we2   = 1'b1;
                n_a2    = s_addr;
                n_d2    = s_data;
                alu_pop = 1'b1;
                ld_pop  = 1'b1;
                // both singles served, so MD is next in line regardless of scan order
                rr_n    = SRC_MD;
            end else begin
                alu_pop = ~ld_first;
                ld_pop  = ld_first;
                rr_n    = src_next(f_src);
            end
        end else if (s_v) begin
            n_we1   = 1'b1;
            n_a1    = s_addr;
            n_d1    = s_data;
            alu_pop = ld_first;
            ld_pop  = ~ld_first;
            rr_n    = src_next(s_src);
        end
    end

    // Issue register and round-robin pointer; each grant is presented for exactly one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_enable1   <= 1'b0;
            w_enable2   <= 1'b0;
            addr1       <= '0;
            addr2       <= '0;
            d1writeback <= '0;
            d2writeback <= '0;
            rr          <= SRC_ALU;
        end else begin
            w_enable1   <= n_we1;
            w_enable2   <= n_we2;
            addr1       <= n_a1;
            addr2       <= n_a2;
            d1writeback <= n_d1;
            d2writeback <= n_d2;
            rr          <= rr_n;
        end
    end

    // MULDIV holding register: ready only when empty, so load and grant never coincide
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            md_v  <= 1'b0;
            md_aa <= '0;
            md_ab <= '0;
            md_da <= '0;
            md_db <= '0;
        end else if (md_valid && md_ready) begin
            md_v  <= 1'b1;
            md_aa <= md_addr_a;
            md_ab <= md_addr_b;
            md_da <= md_data_a;
            md_db <= md_data_b;
        end else if (md_grant) begin
            md_v  <= 1'b0;
        end
    end

    // Pending mask: every accepted write not yet captured by the register file
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (alu_ev[i]) pending[alu_ea[i*AW +: AW]] = 1'b1;
            if (ld_ev[i])  pending[ld_ea[i*AW +: AW]]  = 1'b1;
        end
        if (md_v) begin
            pending[md_aa] = 1'b1;
            pending[md_ab] = 1'b1;
        end
        if (w_enable1) pending[addr1] = 1'b1;
        if (w_enable2) pending[addr2] = 1'b1;
    end

    assign idle = alu_empty & ld_empty & ~md_v & ~w_enable1 & ~w_enable2;

endmodule
